// File: rtl/pram_arbiter.sv
// rtl/pram_arbiter.sv - program-RAM arbiter between instruction fetch and microcode data path
// Data has priority, with fetch anti-starvation, an optional data lock, and tagged one-cycle read return.
module pram_arbiter #(
    parameter int ADDRESS_WIDTH = 16,
    parameter int DATA_WIDTH    = 16,
    parameter int STARVE_LIMIT  = 4
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     fetch_req,
    input  logic [ADDRESS_WIDTH-1:0] fetch_addr,
    output logic                     fetch_gnt,
    output logic                     fetch_valid,
    output logic [DATA_WIDTH-1:0]    fetch_rdata,
    input  logic                     data_req,
    input  logic                     data_rw,
    input  logic [ADDRESS_WIDTH-1:0] data_addr,
    input  logic [DATA_WIDTH-1:0]    data_wdata,
    input  logic                     data_lock,
    output logic                     data_gnt,
    output logic                     data_valid,
    output logic [DATA_WIDTH-1:0]    data_rdata,
    output logic                     ram_enable,
    output logic                     ram_rw,
    output logic [ADDRESS_WIDTH-1:0] ram_address,
    output logic [DATA_WIDTH-1:0]    ram_data_in,
    input  logic [DATA_WIDTH-1:0]    ram_data_out,
    output logic                     busy
);

    typedef enum logic [1:0] {
        OWN_NONE,
        OWN_FETCH,
        OWN_DATA
    } owner_t;

    localparam logic [3:0] LIMIT = STARVE_LIMIT[3:0];

    owner_t                   owner;
    logic [3:0]               starve_count;
    logic                     last_data;
    logic [ADDRESS_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0]    wdata_q;
    logic                     pick_fetch;
    logic                     pick_data;

    // Lock only counts once data actually owned the RAM on the previous issue.
    always_comb begin
        pick_fetch = 1'b0;
        pick_data  = 1'b0;
        if (!reset) begin
            if (data_lock && last_data && data_req) begin
                pick_data = 1'b1;
            end else if ((starve_count >= LIMIT) && fetch_req) begin
                pick_fetch = 1'b1;
            end else if (data_req) begin
                pick_data = 1'b1;
            end else if (fetch_req) begin
                pick_fetch = 1'b1;
            end
        end
    end

    always_comb begin
        fetch_gnt   = pick_fetch;
        data_gnt    = pick_data;
        ram_enable  = pick_fetch | pick_data;
        ram_rw      = pick_data & data_rw;
        ram_address = addr_q;
        ram_data_in = wdata_q;
        if (pick_data) begin
            ram_address = data_addr;
            ram_data_in = data_wdata;
        end else if (pick_fetch) begin
            ram_address = fetch_addr;
        end
    end

    assign busy = (owner != OWN_NONE);

    always_ff @(posedge clock) begin
        if (reset) begin
            owner        <= OWN_NONE;
            starve_count <= 4'd0;
            last_data    <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            fetch_valid  <= 1'b0;
            data_valid   <= 1'b0;
            fetch_rdata  <= '0;
            data_rdata   <= '0;
        end else begin
            if (!fetch_req || pick_fetch) begin
                starve_count <= 4'd0;
            end else if (starve_count < LIMIT) begin
                starve_count <= starve_count + 4'd1;
            end

            if (pick_data) begin
                last_data <= 1'b1;
            end else if (pick_fetch) begin
                last_data <= 1'b0;
            end

            if (pick_data || pick_fetch) begin
                addr_q <= ram_address;
            end
            if (pick_data) begin
                wdata_q <= data_wdata;
            end

            if (pick_fetch) begin
                owner <= OWN_FETCH;
            end else if (pick_data && !data_rw) begin
                owner <= OWN_DATA;
            end else begin
                owner <= OWN_NONE;
            end

            // RAM output is valid while the tag is live; capture it for the tagged owner only.
            fetch_valid <= (owner == OWN_FETCH);
            data_valid  <= (owner == OWN_DATA);
            if (owner == OWN_FETCH) begin
                fetch_rdata <= ram_data_out;
            end
            if (owner == OWN_DATA) begin
                data_rdata <= ram_data_out;
            end
        end
    end

endmodule

// File: tb/tb_pram_arbiter.sv
// tb/tb_pram_arbiter.sv - self-checking bench for pram_arbiter
// Queue-based timing model checked every cycle, plus directed literal expectations.
module tb_pram_arbiter;

    localparam int AW  = 16;
    localparam int DW  = 16;
    localparam int LIM = 4;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          fetch_req = 1'b0;
    logic [AW-1:0] fetch_addr = '0;
    logic          fetch_gnt;
    logic          fetch_valid;
    logic [DW-1:0] fetch_rdata;
    logic          data_req = 1'b0;
    logic          data_rw = 1'b0;
    logic [AW-1:0] data_addr = '0;
    logic [DW-1:0] data_wdata = '0;
    logic          data_lock = 1'b0;
    logic          data_gnt;
    logic          data_valid;
    logic [DW-1:0] data_rdata;
    logic          ram_enable;
    logic          ram_rw;
    logic [AW-1:0] ram_address;
    logic [DW-1:0] ram_data_in;
    logic [DW-1:0] ram_data_out = '0;
    logic          busy;

    always #5 clock = ~clock;

    pram_arbiter #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .STARVE_LIMIT(LIM)) dut (
        .clock(clock), .reset(reset),
        .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_gnt(fetch_gnt),
        .fetch_valid(fetch_valid), .fetch_rdata(fetch_rdata),
        .data_req(data_req), .data_rw(data_rw), .data_addr(data_addr),
        .data_wdata(data_wdata), .data_lock(data_lock), .data_gnt(data_gnt),
        .data_valid(data_valid), .data_rdata(data_rdata),
        .ram_enable(ram_enable), .ram_rw(ram_rw), .ram_address(ram_address),
        .ram_data_in(ram_data_in), .ram_data_out(ram_data_out), .busy(busy)
    );

    function automatic logic [DW-1:0] init_val(int i);
        logic [DW-1:0] v;
        v = 16'(i) * 16'h0301 + 16'h1000;
        if (i == 3) v = 16'h1A05;
        return v;
    endfunction

    // Synchronous single-port RAM: read data appears the cycle after the strobe.
    logic [DW-1:0] mem [0:255];
    bit            loaded = 1'b0;
    always @(posedge clock) begin
        if (!loaded) begin
            for (int i = 0; i < 256; i++) mem[i] <= init_val(i);
            loaded <= 1'b1;
        end else if (ram_enable) begin
            if (ram_rw) mem[ram_address[7:0]] <= ram_data_in;
            else        ram_data_out <= mem[ram_address[7:0]];
        end
    end

    int passed = 0;
    int total  = 0;
    int cyc    = 0;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    typedef struct {
        int            issue;
        bit            is_fetch;
        logic [DW-1:0] data;
    } ret_t;

    ret_t          rq[$];
    logic [DW-1:0] ref_mem [0:255];
    bit            m_last_data = 1'b0;
    int            m_starve = 0;
    logic [DW-1:0] h_f = '0;
    logic [DW-1:0] h_d = '0;

    always @(negedge clock) begin
        bit            wf, wd, ebusy, efv, edv;
        logic [DW-1:0] ef, ed;
        ret_t          e;
        if (cyc == 0) for (int i = 0; i < 256; i++) ref_mem[i] = init_val(i);
        wf = 1'b0;
        wd = 1'b0;
        if (!reset) begin
            if (data_lock && m_last_data && data_req) wd = 1'b1;
            else if (m_starve >= LIM && fetch_req)   wf = 1'b1;
            else if (data_req)                        wd = 1'b1;
            else if (fetch_req)                       wf = 1'b1;
        end
        ebusy = 1'b0; efv = 1'b0; edv = 1'b0; ef = h_f; ed = h_d;
        foreach (rq[i]) begin
            if (rq[i].issue == cyc - 1) ebusy = 1'b1;
            if (rq[i].issue == cyc - 2) begin
                if (rq[i].is_fetch) begin efv = 1'b1; ef = rq[i].data; end
                else                begin edv = 1'b1; ed = rq[i].data; end
            end
        end
        chk("fetch_gnt",   32'(fetch_gnt),   32'(wf));
        chk("data_gnt",    32'(data_gnt),    32'(wd));
        chk("ram_enable",  32'(ram_enable),  32'(wf | wd));
        chk("busy",        32'(busy),        32'(ebusy));
        chk("fetch_valid", 32'(fetch_valid), 32'(efv));
        chk("data_valid",  32'(data_valid),  32'(edv));
        chk("fetch_rdata", 32'(fetch_rdata), 32'(ef));
        chk("data_rdata",  32'(data_rdata),  32'(ed));
        if (wf || wd) begin
            chk("ram_address", 32'(ram_address), 32'(wd ? data_addr : fetch_addr));
            chk("ram_rw",      32'(ram_rw),      32'(wd & data_rw));
        end
        if (wd && data_rw) chk("ram_data_in", 32'(ram_data_in), 32'(data_wdata));
        h_f = ef;
        h_d = ed;
        while (rq.size() > 0 && rq[0].issue <= cyc - 2) void'(rq.pop_front());
        if (reset) begin
            rq.delete();
            m_starve = 0;
            m_last_data = 1'b0;
            h_f = '0;
            h_d = '0;
        end else begin
            if (wf || (wd && !data_rw)) begin
                e.issue    = cyc;
                e.is_fetch = wf;
                e.data     = wf ? ref_mem[fetch_addr[7:0]] : ref_mem[data_addr[7:0]];
                rq.push_back(e);
            end
            if (wd && data_rw) ref_mem[data_addr[7:0]] = data_wdata;
            if (fetch_req && !wf) m_starve = (m_starve < LIM) ? m_starve + 1 : LIM;
            else                  m_starve = 0;
            if (wd)      m_last_data = 1'b1;
            else if (wf) m_last_data = 1'b0;
        end
        cyc++;
    end

    task automatic step;
        @(posedge clock);
        #1;
    endtask

    task automatic idle;
        fetch_req = 1'b0;
        data_req  = 1'b0;
        data_lock = 1'b0;
        data_rw   = 1'b0;
    endtask

    initial begin
        int first_fetch;
        int fcount;
        bit dg5;
        step;
        step;
        fetch_req = 1'b1;
        data_req  = 1'b1;
        #6;
        chk("rst_fetch_gnt", 32'(fetch_gnt), 32'd0);
        chk("rst_data_gnt",  32'(data_gnt),  32'd0);
        chk("rst_ram_en",    32'(ram_enable), 32'd0);
        chk("rst_busy",      32'(busy),       32'd0);
        chk("rst_rdata",     32'(data_rdata), 32'd0);

        step; reset = 1'b0; idle; fetch_req = 1'b1; fetch_addr = 16'h0003;
        #6;
        chk("f3_gnt",  32'(fetch_gnt),   32'd1);
        chk("f3_rw",   32'(ram_rw),      32'd0);
        chk("f3_addr", 32'(ram_address), 32'h0003);
        step; idle;
        #6;
        chk("f3_busy", 32'(busy), 32'd1);
        step;
        #6;
        chk("f3_valid", 32'(fetch_valid), 32'd1);
        chk("f3_rdata", 32'(fetch_rdata), 32'h1A05);

        step; data_req = 1'b1; data_rw = 1'b1; data_addr = 16'h0010; data_wdata = 16'hBEEF;
        #6;
        chk("wr_gnt", 32'(data_gnt),    32'd1);
        chk("wr_rw",  32'(ram_rw),      32'd1);
        chk("wr_din", 32'(ram_data_in), 32'hBEEF);
        step; data_rw = 1'b0;
        #6;
        chk("rd_gnt",      32'(data_gnt), 32'd1);
        chk("wr_no_busy",  32'(busy),     32'd0);
        step; idle;
        #6;
        chk("wr_no_valid", 32'(data_valid), 32'd0);
        step;
        #6;
        chk("rd_valid", 32'(data_valid), 32'd1);
        chk("rd_rdata", 32'(data_rdata), 32'hBEEF);

        step; fetch_req = 1'b1; fetch_addr = 16'h0007; data_req = 1'b1; data_addr = 16'h0008;
        first_fetch = -1;
        dg5 = 1'b0;
        for (int k = 0; k < 6; k++) begin
            #6;
            if (fetch_gnt && first_fetch < 0) first_fetch = k;
            if (k == 5) dg5 = data_gnt;
            step;
        end
        chk("starve_first_fetch", 32'(first_fetch), 32'd4);
        chk("starve_data_resume", 32'(dg5),         32'd1);

        idle; data_req = 1'b1; data_lock = 1'b1; data_addr = 16'h0009;
        #6;
        chk("lock_first_gnt", 32'(data_gnt), 32'd1);
        step; fetch_req = 1'b1; fetch_addr = 16'h0004;
        fcount = 0;
        for (int k = 0; k < 10; k++) begin
            #6;
            fcount += 32'(fetch_gnt);
            step;
        end
        chk("lock_fetch_count", 32'(fcount), 32'd0);
        data_lock = 1'b0;
        #6;
        chk("unlock_fetch_gnt", 32'(fetch_gnt), 32'd1);
        chk("unlock_data_gnt",  32'(data_gnt),  32'd0);

        step; idle; fetch_req = 1'b1; fetch_addr = 16'h0001;
        step; idle; data_req = 1'b1; data_addr = 16'h0002;
        step; idle; fetch_req = 1'b1; fetch_addr = 16'h0003;
        #6;
        chk("alt1_fvalid", 32'(fetch_valid), 32'd1);
        chk("alt1_frdata", 32'(fetch_rdata), 32'(init_val(1)));
        chk("alt1_dvalid", 32'(data_valid),  32'd0);
        step; idle;
        #6;
        chk("alt2_dvalid", 32'(data_valid),  32'd1);
        chk("alt2_drdata", 32'(data_rdata),  32'(init_val(2)));
        chk("alt2_fvalid", 32'(fetch_valid), 32'd0);
        step;
        #6;
        chk("alt3_fvalid", 32'(fetch_valid), 32'd1);
        chk("alt3_frdata", 32'(fetch_rdata), 32'h1A05);

        step; fetch_req = 1'b1; fetch_addr = 16'h0005;
        step; idle; reset = 1'b1;
        step; reset = 1'b0;
        #6;
        chk("rr_fvalid", 32'(fetch_valid), 32'd0);
        chk("rr_dvalid", 32'(data_valid),  32'd0);
        chk("rr_busy",   32'(busy),        32'd0);
        chk("rr_frdata", 32'(fetch_rdata), 32'd0);
        chk("rr_drdata", 32'(data_rdata),  32'd0);
        step;
        step;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
